// File: rtl/ro_fifo_read_arbiter.sv
// Round-robin read scheduler: grants one non-empty RO FIFO at a time and streams its packet out word by word.
// Latency: 1 cycle arbitration, then POP/CAPT/HOLD per word (>= 3 cycles/word); FIFO read latency is 1.
// Backpressure: OutValid/OutData/OutEop hold in HOLD until OutReady; no FIFO read happens while held.
// Optional build macro RO_ARB_TIMEOUT_EN: aborts a starved packet after TIMEOUT cycles in WAIT.
module ro_fifo_read_arbiter #(
    parameter int NUM_FIFO    = 4,
    parameter int GRANT_WIDTH = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                           BC,
    input  logic                           Reset,
    input  logic [NUM_FIFO-1:0]            Empty,
    input  logic [NUM_FIFO*DATA_WIDTH-1:0] FifoData,
    input  logic [NUM_FIFO-1:0]            FifoEop,
    output logic [NUM_FIFO-1:0]            ReadEnable,
    output logic [DATA_WIDTH-1:0]          OutData,
    output logic                           OutEop,
    output logic                           OutValid,
    input  logic                           OutReady,
    output logic [GRANT_WIDTH-1:0]         GrantIdx,
    output logic                           Busy,
    output logic                           TimeoutErr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_CAPT = 3'd2,
        S_HOLD = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    localparam logic [7:0]             TO8      = 8'(TIMEOUT);
    localparam logic [GRANT_WIDTH-1:0] LAST_IDX = GRANT_WIDTH'(NUM_FIFO - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [GRANT_WIDTH-1:0]  rr_ptr;
    logic [GRANT_WIDTH-1:0]  ptr_after_grant;

    // Round-robin search results
    logic                    hit_hi;
    logic                    hit_lo;
    logic [GRANT_WIDTH-1:0]  idx_hi;
    logic [GRANT_WIDTH-1:0]  idx_lo;
    logic                    req_any;
    logic [GRANT_WIDTH-1:0]  req_idx;

    // Granted FIFO's view
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_eop;
    logic                    sel_empty;

    logic                    accept;
    logic                    pkt_done;
    logic                    abort;

    // Find the first non-empty FIFO at or above the pointer (hi) and the first overall (lo, used on wrap)
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = NUM_FIFO - 1; i >= 0; i--) begin
            if (!Empty[i]) begin
                hit_lo = 1'b1;
                idx_lo = GRANT_WIDTH'(i);
                if (i >= int'(rr_ptr)) begin
                    hit_hi = 1'b1;
                    idx_hi = GRANT_WIDTH'(i);
                end
            end
        end
    end

    assign req_any = hit_hi | hit_lo;
    assign req_idx = hit_hi ? idx_hi : idx_lo;

    // Route the granted FIFO's data, eop and empty flag
    always_comb begin
        sel_data  = '0;
        sel_eop   = 1'b0;
        sel_empty = 1'b1;
        for (int i = 0; i < NUM_FIFO; i++) begin
            if (GrantIdx == GRANT_WIDTH'(i)) begin
                sel_data  = FifoData[i*DATA_WIDTH +: DATA_WIDTH];
                sel_eop   = FifoEop[i];
                sel_empty = Empty[i];
            end
        end
    end

    assign accept          = (state == S_HOLD) && OutReady;
    assign pkt_done        = accept && OutEop;
    assign ptr_after_grant = (GrantIdx == LAST_IDX) ? '0 : GrantIdx + 1'b1;

`ifdef RO_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout_err_q;

    // The TIMEOUT-th consecutive WAIT cycle without data ends the packet
    assign abort = (state == S_WAIT) && sel_empty && (wait_cnt == TO8 - 8'd1);

    // WAIT-cycle counter and sticky abort flag
    always_ff @(posedge BC) begin
        if (Reset) begin
            wait_cnt      <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state != S_WAIT) begin
                wait_cnt <= 8'd0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (abort) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign TimeoutErr = timeout_err_q;
`else
    logic [7:0] unused_timeout;

    assign unused_timeout = TO8;
    assign abort          = 1'b0;
    assign TimeoutErr     = 1'b0;
`endif

    // State register
    always_ff @(posedge BC) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the grant is only re-evaluated in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_any) begin
                    state_nxt = S_POP;
                end
            end
            S_POP: begin
                state_nxt = S_CAPT;
            end
            S_CAPT: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (OutReady) begin
                    if (OutEop) begin
                        state_nxt = S_IDLE;
                    end else if (!sel_empty) begin
                        state_nxt = S_POP;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!sel_empty) begin
                    state_nxt = S_POP;
                end else if (abort) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Decoded outputs: read strobe only in POP, busy outside IDLE
    always_comb begin
        ReadEnable = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            ReadEnable[i] = (state == S_POP) && (GrantIdx == GRANT_WIDTH'(i));
        end
        Busy = (state != S_IDLE);
    end

    // Grant latch, round-robin pointer and output word register
    always_ff @(posedge BC) begin
        if (Reset) begin
            GrantIdx <= '0;
            rr_ptr   <= '0;
            OutData  <= '0;
            OutEop   <= 1'b0;
            OutValid <= 1'b0;
        end else begin
            if ((state == S_IDLE) && req_any) begin
                GrantIdx <= req_idx;
            end
            if (pkt_done || abort) begin
                rr_ptr <= ptr_after_grant;
            end
            if (state == S_CAPT) begin
                OutData  <= sel_data;
                OutEop   <= sel_eop;
                OutValid <= 1'b1;
            end else if (accept) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ro_fifo_read_arbiter.sv
// Directed bench for ro_fifo_read_arbiter with a behavioural 4-FIFO model (read latency 1).
// Stimulus is driven and outputs are checked 1 time unit after the rising edge of BC.
// The FIFO model and the grant/word logger run on the falling edge.
module tb_ro_fifo_read_arbiter;

    localparam int NF = 4;
    localparam int DW = 16;
`ifdef RO_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    localparam int STARVE = (TO > 20) ? 20 : TO - 3;

    logic              BC = 1'b0;
    logic              Reset = 1'b1;
    logic [NF-1:0]     Empty = '1;
    logic [NF*DW-1:0]  FifoData = '0;
    logic [NF-1:0]     FifoEop = '0;
    logic              OutReady = 1'b0;
    logic [NF-1:0]     ReadEnable;
    logic [DW-1:0]     OutData;
    logic              OutEop;
    logic              OutValid;
    logic [1:0]        GrantIdx;
    logic              Busy;
    logic              TimeoutErr;

    logic [DW:0]       fq [NF][$];
    logic [NF-1:0]     re_log[$];
    logic [DW:0]       wd_log[$];
    logic [DW:0]       w;
    int                re_viol = 0;
    int                errors = 0;
    int                checks = 0;

    ro_fifo_read_arbiter #(
        .NUM_FIFO(NF), .GRANT_WIDTH(2), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .BC(BC), .Reset(Reset), .Empty(Empty), .FifoData(FifoData), .FifoEop(FifoEop),
        .ReadEnable(ReadEnable), .OutData(OutData), .OutEop(OutEop), .OutValid(OutValid),
        .OutReady(OutReady), .GrantIdx(GrantIdx), .Busy(Busy), .TimeoutErr(TimeoutErr)
    );

    initial forever #5 BC = ~BC;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // FIFO model (pop on strobe, flush on reset) plus grant/accepted-word logger
    always @(negedge BC) begin
        if (|ReadEnable) re_log.push_back(ReadEnable);
        if (OutValid && OutReady) wd_log.push_back({OutEop, OutData});
        for (int i = 0; i < NF; i++) begin
            if (Reset) begin
                fq[i].delete();
            end else if (ReadEnable[i]) begin
                if (fq[i].size() == 0) begin
                    re_viol++;
                end else begin
                    w = fq[i].pop_front();
                    FifoData[i*DW +: DW] = w[DW-1:0];
                    FifoEop[i] = w[DW];
                end
            end
            Empty[i] = (fq[i].size() == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge BC);
        #1;
    endtask

    task automatic push(input int f, input logic [DW-1:0] d, input logic e);
        fq[f].push_back({e, d});
    endtask

    task automatic clear_logs();
        re_log.delete();
        wd_log.delete();
    endtask

    task automatic wait_words(input int n, input string tag);
        int k = 0;
        while (wd_log.size() < n && k < 300) begin
            tick(1);
            k++;
        end
        chk(tag, wd_log.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (Busy && k < 300) begin
            tick(1);
            k++;
        end
        chk(tag, {31'd0, Busy}, 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!OutValid && k < 100) begin
            tick(1);
            k++;
        end
        chk(tag, {31'd0, OutValid}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_re"},   ReadEnable, 0);
        chk({tag, "_data"}, OutData, 0);
        chk({tag, "_eop"},  OutEop, 0);
        chk({tag, "_vld"},  OutValid, 0);
        chk({tag, "_gnt"},  GrantIdx, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_terr"}, TimeoutErr, 0);
    endtask

    initial begin
        // Reset state
        Reset = 1'b1;
        OutReady = 1'b0;
        tick(2);
        chk_all_zero("rst");
        Reset = 1'b0;
        tick(1);

        // Single 3-word packet from FIFO2
        clear_logs();
        OutReady = 1'b1;
        push(2, 16'h0A01, 1'b0);
        push(2, 16'h0A02, 1'b0);
        push(2, 16'h0A03, 1'b1);
        wait_words(3, "t2_nwords");
        wait_idle("t2_idle");
        chk("t2_nre", re_log.size(), 3);
        for (int k = 0; k < 3; k++) chk("t2_re", re_log[k], 4'b0100);
        chk("t2_w0", wd_log[0], {1'b0, 16'h0A01});
        chk("t2_w1", wd_log[1], {1'b0, 16'h0A02});
        chk("t2_w2", wd_log[2], {1'b1, 16'h0A03});
        chk("t2_gnt", GrantIdx, 2);

        // Fairness: pointer back to 0, all four FIFOs request at once
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(1);
        clear_logs();
        push(0, 16'h3000, 1'b1);
        push(1, 16'h3101, 1'b1);
        push(2, 16'h3202, 1'b1);
        push(3, 16'h3303, 1'b1);
        wait_words(4, "t3_nwords");
        wait_idle("t3_idle");
        chk("t3_re0", re_log[0], 4'b0001);
        chk("t3_re1", re_log[1], 4'b0010);
        chk("t3_re2", re_log[2], 4'b0100);
        chk("t3_re3", re_log[3], 4'b1000);
        chk("t3_w3", wd_log[3], {1'b1, 16'h3303});
        // Refill FIFO0 and FIFO3 together: FIFO0 goes first after FIFO3 was served
        clear_logs();
        push(3, 16'h3313, 1'b1);
        push(0, 16'h3010, 1'b1);
        wait_words(2, "t3b_nwords");
        wait_idle("t3b_idle");
        chk("t3b_re0", re_log[0], 4'b0001);
        chk("t3b_re1", re_log[1], 4'b1000);
        // Serve FIFO1 so the pointer sits at 2, then FIFO0+FIFO3: FIFO3 wins
        clear_logs();
        push(1, 16'h3121, 1'b1);
        wait_words(1, "t3c_nwords");
        wait_idle("t3c_idle");
        clear_logs();
        push(0, 16'h3030, 1'b1);
        push(3, 16'h3333, 1'b1);
        wait_words(2, "t3d_nwords");
        wait_idle("t3d_idle");
        chk("t3d_re0", re_log[0], 4'b1000);
        chk("t3d_re1", re_log[1], 4'b0001);
        chk("t3d_w0", wd_log[0], {1'b1, 16'h3333});

        // Backpressure: 10 cycles of OutReady=0 in HOLD
        clear_logs();
        OutReady = 1'b0;
        push(1, 16'h4B01, 1'b0);
        push(1, 16'h4B02, 1'b1);
        wait_valid("t4_valid");
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("t4_hold_vld", OutValid, 1);
            chk("t4_hold_data", OutData, 16'h4B01);
            chk("t4_hold_eop", OutEop, 0);
        end
        chk("t4_nre_held", re_log.size(), 1);
        chk("t4_nwords_held", wd_log.size(), 0);
        OutReady = 1'b1;
        wait_words(2, "t4_nwords");
        wait_idle("t4_idle");
        chk("t4_w0", wd_log[0], {1'b0, 16'h4B01});
        chk("t4_w1", wd_log[1], {1'b1, 16'h4B02});
        chk("t4_nre", re_log.size(), 2);

        // Starved packet: FIFO1 stalls mid-packet while FIFO3 requests
        clear_logs();
        push(1, 16'h5C01, 1'b0);
        wait_words(1, "t5_first");
        tick(1);
        push(3, 16'h5C33, 1'b1);
        for (int k = 0; k < STARVE; k++) begin
            tick(1);
            chk("t5_gnt", GrantIdx, 1);
            chk("t5_busy", Busy, 1);
        end
        chk("t5_nre_starved", re_log.size(), 1);
        push(1, 16'h5C02, 1'b1);
        wait_words(3, "t5_nwords");
        wait_idle("t5_idle");
        chk("t5_w1", wd_log[1], {1'b1, 16'h5C02});
        chk("t5_w2", wd_log[2], {1'b1, 16'h5C33});
        chk("t5_re1", re_log[1], 4'b0010);
        chk("t5_re2", re_log[2], 4'b1000);
        chk("t5_gnt_end", GrantIdx, 3);

        // Reset asserted mid-HOLD with OutValid=1
        clear_logs();
        OutReady = 1'b0;
        push(0, 16'h1A01, 1'b0);
        push(0, 16'h1A02, 1'b1);
        wait_valid("t1_valid");
        chk("t1_data_pre", OutData, 16'h1A01);
        Reset = 1'b1;
        tick(1);
        chk_all_zero("t1");
        Reset = 1'b0;
        OutReady = 1'b1;
        tick(6);
        chk("t1_nre_after", re_log.size(), 1);
        chk("t1_nwords_after", wd_log.size(), 0);
        chk("t1_busy_after", Busy, 0);

`ifdef RO_ARB_TIMEOUT_EN
        // Timeout: FIFO2 starves in WAIT, abort after TO cycles, next grant is FIFO3
        begin
            int k = 0;
            clear_logs();
            push(2, 16'h6601, 1'b0);
            wait_words(1, "t6_first");
            while (Busy && k < 100) begin
                tick(1);
                k++;
            end
            chk("t6_wait_cycles", k, TO);
            chk("t6_terr", TimeoutErr, 1);
            chk("t6_gnt", GrantIdx, 2);
            push(0, 16'h6600, 1'b1);
            push(3, 16'h6633, 1'b1);
            wait_words(3, "t6_nwords");
            wait_idle("t6_idle");
            chk("t6_re1", re_log[1], 4'b1000);
            chk("t6_re2", re_log[2], 4'b0001);
            chk("t6_terr_sticky", TimeoutErr, 1);
        end
`else
        chk("t6_terr_tied", TimeoutErr, 0);
`endif

        chk("re_on_empty", re_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
